// File: rtl/ttt_game_ctrl.sv
// ttt_game_ctrl: turn sequencer and rule engine for the two-player tic-tac-toe
// display. Validates moves, alternates turns, detects win/draw, enforces an
// optional per-turn timeout and hands the board to the renderer on frame start.
//
// state | meaning
// PLAY  | waiting for the current player's move (turn timer running)
// CHECK | one cycle: test the mover's grid for a line or a full board
// WIN   | game over, winner and win_line valid
// DRAW  | game over, board full with no line
module ttt_game_ctrl #(
   parameter int unsigned TURN_TIMEOUT = 250000000
) (
   input  logic       dclk,
   input  logic       clr,
   input  logic       new_game,
   input  logic       move_valid,
   input  logic [3:0] move_idx,
   input  logic       frame_start,
   output logic [8:0] g1Grid_vg,
   output logic [8:0] g2Grid_vg,
   output logic       turn,
   output logic [1:0] game_state,
   output logic [1:0] winner,
   output logic [8:0] win_line,
   output logic       move_ack,
   output logic       move_err,
   output logic       turn_timeout
);

   localparam bit          TO_EN = (TURN_TIMEOUT > 0);
   localparam int unsigned TW    = TO_EN ? $clog2(TURN_TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] TC_LAST = TO_EN ? TW'(TURN_TIMEOUT - 1) : '0;

   localparam logic [8:0] L_R0 = 9'h007;
   localparam logic [8:0] L_R1 = 9'h038;
   localparam logic [8:0] L_R2 = 9'h1C0;
   localparam logic [8:0] L_C0 = 9'h049;
   localparam logic [8:0] L_C1 = 9'h092;
   localparam logic [8:0] L_C2 = 9'h124;
   localparam logic [8:0] L_D0 = 9'h111;
   localparam logic [8:0] L_D1 = 9'h054;

   typedef enum logic [1:0] {
      S_PLAY  = 2'b00,
      S_CHECK = 2'b01,
      S_WIN   = 2'b10,
      S_DRAW  = 2'b11
   } state_t;

   state_t        r_state;
   logic [8:0]    r_w1, r_w2, r_g1, r_g2, r_win_line;
   logic [1:0]    r_winner;
   logic          r_turn, r_ack, r_err, r_to;
   logic [TW-1:0] r_tcnt;

   logic [8:0]    w_occ, w_sel, w_mover, w_line;
   logic          w_legal, w_expire;

   assign w_occ    = r_w1 | r_w2;
   // Indices 9..15 shift the bit out entirely, so w_sel is 0 for them.
   assign w_sel    = 9'h001 << move_idx;
   assign w_legal  = (move_idx <= 4'd8) && ((w_occ & w_sel) == 9'h000);
   assign w_mover  = r_turn ? r_w2 : r_w1;
   // >= rather than ==: a move that masks the expiry cycle lets tcnt pass
   // TURN_TIMEOUT-1 by one, and the forfeit must then follow, not wrap.
   assign w_expire = TO_EN && (r_tcnt >= TC_LAST);

   // First fully-set line of the mover, in fixed row/column/diagonal priority.
   always_comb begin
      w_line = '0;
      if      ((w_mover & L_R0) == L_R0) w_line = L_R0;
      else if ((w_mover & L_R1) == L_R1) w_line = L_R1;
      else if ((w_mover & L_R2) == L_R2) w_line = L_R2;
      else if ((w_mover & L_C0) == L_C0) w_line = L_C0;
      else if ((w_mover & L_C1) == L_C1) w_line = L_C1;
      else if ((w_mover & L_C2) == L_C2) w_line = L_C2;
      else if ((w_mover & L_D0) == L_D0) w_line = L_D0;
      else if ((w_mover & L_D1) == L_D1) w_line = L_D1;
   end

   // Game FSM, turn timer, registered status/pulses and frame-synchronous copy.
   always_ff @(posedge dclk or posedge clr) begin
      if (clr) begin
         r_state    <= S_PLAY;
         r_w1       <= '0;
         r_w2       <= '0;
         r_g1       <= '0;
         r_g2       <= '0;
         r_win_line <= '0;
         r_winner   <= '0;
         r_turn     <= 1'b0;
         r_ack      <= 1'b0;
         r_err      <= 1'b0;
         r_to       <= 1'b0;
         r_tcnt     <= '0;
      end else begin
         r_ack <= 1'b0;
         r_err <= 1'b0;
         r_to  <= 1'b0;

         // Non-blocking reads give the pre-write board when a write coincides.
         if (frame_start) begin
            r_g1 <= r_w1;
            r_g2 <= r_w2;
         end

         if (new_game) begin
            r_w1       <= '0;
            r_w2       <= '0;
            r_winner   <= '0;
            r_win_line <= '0;
            r_tcnt     <= '0;
            r_turn     <= 1'b0;
            r_state    <= S_PLAY;
         end else begin
            case (r_state)
               S_PLAY: begin
                  if (move_valid) begin
                     if (w_legal) begin
                        if (r_turn) r_w2 <= r_w2 | w_sel;
                        else        r_w1 <= r_w1 | w_sel;
                        r_ack   <= 1'b1;
                        r_tcnt  <= '0;
                        r_state <= S_CHECK;
                     end else begin
                        r_err <= 1'b1;
                        if (TO_EN) r_tcnt <= r_tcnt + 1'b1;
                     end
                  end else if (w_expire) begin
                     r_to   <= 1'b1;
                     r_turn <= ~r_turn;
                     r_tcnt <= '0;
                  end else if (TO_EN) begin
                     r_tcnt <= r_tcnt + 1'b1;
                  end
               end
               S_CHECK: begin
                  if (w_line != 9'h000) begin
                     r_state    <= S_WIN;
                     r_winner   <= r_turn ? 2'b10 : 2'b01;
                     r_win_line <= w_line;
                  end else if (w_occ == 9'h1FF) begin
                     r_state <= S_DRAW;
                  end else begin
                     r_turn  <= ~r_turn;
                     r_tcnt  <= '0;
                     r_state <= S_PLAY;
                  end
               end
               default: begin
                  if (move_valid) r_err <= 1'b1;
               end
            endcase
         end
      end
   end

   assign g1Grid_vg    = r_g1;
   assign g2Grid_vg    = r_g2;
   assign turn         = r_turn;
   assign game_state   = r_state;
   assign winner       = r_winner;
   assign win_line     = r_win_line;
   assign move_ack     = r_ack;
   assign move_err     = r_err;
   assign turn_timeout = r_to;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// tb_ttt_game_ctrl: directed games against ttt_game_ctrl. Stimulus queues the
// pulse it expects (ack/err/timeout); a negedge monitor pops and compares each
// pulse the DUT presents. Board/status values are checked at posedge+1.
module tb_ttt_game_ctrl;

   logic       dclk = 1'b0;
   logic       clr, new_game, move_valid, frame_start;
   logic [3:0] move_idx;
   logic [8:0] g1Grid_vg, g2Grid_vg, win_line;
   logic       turn, move_ack, move_err, turn_timeout;
   logic [1:0] game_state, winner;

   localparam logic [2:0] E_ACK = 3'b001;
   localparam logic [2:0] E_ERR = 3'b010;
   localparam logic [2:0] E_TO  = 3'b100;

   logic [2:0] exp_q[$];
   int         n_vec = 0;
   int         n_err = 0;

   ttt_game_ctrl #(.TURN_TIMEOUT(10)) dut (
      .dclk         (dclk),
      .clr          (clr),
      .new_game     (new_game),
      .move_valid   (move_valid),
      .move_idx     (move_idx),
      .frame_start  (frame_start),
      .g1Grid_vg    (g1Grid_vg),
      .g2Grid_vg    (g2Grid_vg),
      .turn         (turn),
      .game_state   (game_state),
      .winner       (winner),
      .win_line     (win_line),
      .move_ack     (move_ack),
      .move_err     (move_err),
      .turn_timeout (turn_timeout)
   );

   always #5 dclk = ~dclk;

   task automatic tick();
      @(posedge dclk);
      #1;
   endtask

   task automatic chk(input string name, input logic [8:0] act, input logic [8:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, expv);
      end
   endtask

   task automatic do_move(input logic [3:0] idx, input logic [2:0] e, input bit frame);
      move_valid = 1'b1;
      move_idx   = idx;
      exp_q.push_back(e);
      tick();
      move_valid = 1'b0;
      tick();
      frame_start = frame;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic pulse_frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   // Scoreboard monitor: every pulse the DUT raises must match the queue head.
   always @(negedge dclk) begin
      logic [2:0] obs;
      logic [2:0] e;
      if (!clr) begin
         obs = {turn_timeout, move_err, move_ack};
         if (obs != 3'b000) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL pulse_unexpected: got %b, expected none", obs);
            end else begin
               e = exp_q.pop_front();
               if (obs !== e) begin
                  n_err++;
                  $display("FAIL pulse: got %b, expected %b", obs, e);
               end
            end
         end
      end
   end

   initial begin
      logic [3:0] draw_seq [9];
      bit torn;
      draw_seq = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd5, 4'd7, 4'd6, 4'd8};

      clr = 1'b1; new_game = 1'b0; move_valid = 1'b0; move_idx = 4'd0; frame_start = 1'b0;
      repeat (3) tick();
      chk("rst_state",  {7'b0, game_state}, 9'h000);
      chk("rst_turn",   {8'b0, turn}, 9'h000);
      chk("rst_winner", {7'b0, winner}, 9'h000);
      chk("rst_line",   win_line, 9'h000);
      chk("rst_g1",     g1Grid_vg, 9'h000);
      chk("rst_g2",     g2Grid_vg, 9'h000);
      chk("rst_pulses", {6'b0, move_ack, move_err, turn_timeout}, 9'h000);
      clr = 1'b0;

      // P1 row win; last move without frame_start to check tearing.
      do_move(4'd0, E_ACK, 1'b1);
      do_move(4'd3, E_ACK, 1'b1);
      do_move(4'd1, E_ACK, 1'b1);
      do_move(4'd4, E_ACK, 1'b1);
      chk("g1_mid", g1Grid_vg, 9'h003);
      chk("g2_mid", g2Grid_vg, 9'h018);
      do_move(4'd2, E_ACK, 1'b0);
      chk("win_state",  {7'b0, game_state}, 9'h002);
      chk("win_winner", {7'b0, winner}, 9'h001);
      chk("win_line",   win_line, 9'h007);
      chk("win_turn",   {8'b0, turn}, 9'h000);
      torn = 1'b0;
      repeat (1000) begin
         tick();
         if (g1Grid_vg !== 9'h003 || g2Grid_vg !== 9'h018) torn = 1'b1;
      end
      chk("no_tear", {8'b0, torn}, 9'h000);
      pulse_frame();
      chk("win_g1", g1Grid_vg, 9'h007);
      chk("win_g2", g2Grid_vg, 9'h018);
      do_move(4'd5, E_ERR, 1'b0);

      // new_game beats move_valid in WIN.
      new_game = 1'b1; move_valid = 1'b1; move_idx = 4'd5;
      tick();
      new_game = 1'b0; move_valid = 1'b0;
      chk("ng_win_state",  {7'b0, game_state}, 9'h000);
      chk("ng_win_turn",   {8'b0, turn}, 9'h000);
      chk("ng_win_winner", {7'b0, winner}, 9'h000);
      chk("ng_win_line",   win_line, 9'h000);
      chk("ng_win_g1_old", g1Grid_vg, 9'h007);
      pulse_frame();
      chk("ng_win_g1", g1Grid_vg, 9'h000);
      chk("ng_win_g2", g2Grid_vg, 9'h000);

      // Illegal moves: occupied cell, then out-of-range index.
      do_move(4'd4, E_ACK, 1'b1);
      do_move(4'd4, E_ERR, 1'b1);
      do_move(4'd9, E_ERR, 1'b1);
      chk("ill_turn",  {8'b0, turn}, 9'h001);
      chk("ill_g1",    g1Grid_vg, 9'h010);
      chk("ill_g2",    g2Grid_vg, 9'h000);
      chk("ill_state", {7'b0, game_state}, 9'h000);

      // new_game beats move_valid in PLAY.
      new_game = 1'b1; move_valid = 1'b1; move_idx = 4'd0;
      tick();
      new_game = 1'b0; move_valid = 1'b0;
      chk("ng_play_turn",   {8'b0, turn}, 9'h000);
      chk("ng_play_state",  {7'b0, game_state}, 9'h000);
      chk("ng_play_g1_old", g1Grid_vg, 9'h010);
      pulse_frame();
      chk("ng_play_g1", g1Grid_vg, 9'h000);
      chk("ng_play_g2", g2Grid_vg, 9'h000);

      // Draw.
      for (int i = 0; i < 9; i++) do_move(draw_seq[i], E_ACK, 1'b1);
      chk("draw_state",  {7'b0, game_state}, 9'h003);
      chk("draw_winner", {7'b0, winner}, 9'h000);
      chk("draw_line",   win_line, 9'h000);
      chk("draw_full",   g1Grid_vg | g2Grid_vg, 9'h1FF);
      chk("draw_g1",     g1Grid_vg, 9'h18D);
      chk("draw_g2",     g2Grid_vg, 9'h072);
      chk("draw_turn",   {8'b0, turn}, 9'h000);
      do_move(4'd0, E_ERR, 1'b0);

      // Timeout: forfeits every 10 cycles, then a move on the expiry cycle.
      new_game = 1'b1;
      tick();
      new_game = 1'b0;
      exp_q.push_back(E_TO);
      exp_q.push_back(E_TO);
      repeat (9) tick();
      chk("to_before_1", {8'b0, turn}, 9'h000);
      tick();
      chk("to_after_1", {8'b0, turn}, 9'h001);
      repeat (9) tick();
      chk("to_before_2", {8'b0, turn}, 9'h001);
      tick();
      chk("to_after_2", {8'b0, turn}, 9'h000);
      repeat (9) tick();
      do_move(4'd4, E_ACK, 1'b1);
      chk("to_move_turn", {8'b0, turn}, 9'h001);
      chk("to_move_g1",   g1Grid_vg, 9'h010);

      // Asynchronous clear mid-game, between clock edges.
      #3;
      clr = 1'b1;
      #1;
      chk("aclr_g1",     g1Grid_vg, 9'h000);
      chk("aclr_turn",   {8'b0, turn}, 9'h000);
      chk("aclr_state",  {7'b0, game_state}, 9'h000);
      chk("aclr_pulses", {6'b0, move_ack, move_err, turn_timeout}, 9'h000);
      repeat (2) tick();

      chk("exp_q_empty", 9'(exp_q.size()), 9'h000);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ttt_game_ctrl.md
# ttt_game_ctrl

Turn sequencer and rule engine for the two-player tic-tac-toe display. Accepts move requests (cell index 0-8) from the input front end and alternates turns between player 1 and player 2. Rejects illegal moves, detects win and draw, and enforces an optional per-turn timeout. The working board is copied to the VGA renderer's `g1Grid_vg` / `g2Grid_vg` inputs only on a frame-start pulse, so the display never changes mid-frame.

## Interface
- `TURN_TIMEOUT`, default 250000000: cycles allowed per turn (10 s at 25 MHz); 0 disables the timeout.
- `dclk` input 1: pixel clock, 25 MHz; the only clock.
- `clr` input 1: reset, asynchronous, active-high.
- `new_game` input 1: single-cycle pulse; restarts the game.
- `move_valid` input 1: single-cycle pulse; a move request from the current player.
- `move_idx` input 4: requested cell, row-major; 0 = top-left, 8 = bottom-right.
- `frame_start` input 1: single-cycle pulse at the start of vertical blanking.
- `g1Grid_vg` output 9: player 1 occupancy as displayed; bit i = cell i.
- `g2Grid_vg` output 9: player 2 occupancy as displayed.
- `turn` output 1: player to move; 0 = P1, 1 = P2.
- `game_state` output 2: 00 PLAY, 01 CHECK, 10 WIN, 11 DRAW.
- `winner` output 2: 00 none, 01 P1, 10 P2.
- `win_line` output 9: cell mask of the winning line; 0 unless in WIN.
- `move_ack` output 1: 1-cycle pulse; move accepted.
- `move_err` output 1: 1-cycle pulse; move rejected.
- `turn_timeout` output 1: 1-cycle pulse; turn forfeited by timeout.

## Operation
- **Internal state:** working grids `w1`, `w2` (9 bits each), FSM, turn counter `tcnt` (width `$clog2(TURN_TIMEOUT+1)`, minimum 1).
- **Reset (`clr`=1):**
  - All outputs, working grids and `tcnt` are 0.
  - FSM is PLAY and `turn` = 0.
- **PLAY state, `move_valid`=1:**
  - The move is legal iff `move_idx` ≤ 8 and bit `move_idx` is 0 in both `w1|w2`.
  - Legal move:
    - Set the bit in the current player's working grid.
    - Pulse `move_ack`, clear `tcnt`, go to CHECK.
  - Illegal move: pulse `move_err`; nothing else changes.
- **CHECK state (exactly 1 cycle):** test the mover's grid against 8 lines, in this fixed priority order:
  - rows {0,1,2}, {3,4,5}, {6,7,8};
  - columns {0,3,6}, {1,4,7}, {2,5,8};
  - diagonals {0,4,8}, {2,4,6}.
- **CHECK outcome:**
  - Any line fully set → WIN. `winner` = mover + 1. `win_line` = the first matching line in priority order.
  - Otherwise, if `w1|w2` = 9'h1FF → DRAW. `turn` is unchanged.
  - Otherwise → toggle `turn`, clear `tcnt`, return to PLAY.
- **`move_valid` in other states:**
  - In CHECK: ignored; no ack, no err.
  - In WIN or DRAW: pulses `move_err`.
- **Timeout (`TURN_TIMEOUT` > 0, PLAY only):**
  - `tcnt` increments every cycle.
  - When `tcnt` = `TURN_TIMEOUT`-1 and no `move_valid` is present: pulse `turn_timeout`, toggle `turn`, clear `tcnt`.
  - A legal or illegal `move_valid` in the expiry cycle takes priority; the timeout is not taken that cycle.
  - An illegal move does not clear `tcnt`.
- **`new_game` (any state):**
  - Clears `w1`, `w2`, `winner`, `win_line`, `tcnt`; sets `turn` = 0 and FSM = PLAY.
  - Beats `move_valid` and timeout in the same cycle; no ack or err is produced.
- **Display copy:**
  - On every `frame_start`, `g1Grid_vg` ← `w1` and `g2Grid_vg` ← `w2`.
  - The display outputs never change at any other time, including after `new_game`.
  - If `frame_start` coincides with a grid write, the copy takes the pre-write value.

## Timing
- Legal move sampled at edge N:
  - `move_ack` and `game_state` = CHECK visible after N+1.
  - `turn` toggle or WIN/DRAW result visible after N+2.
- Illegal move sampled at N: `move_err` high for the cycle after N+1 only.
- Back-to-back `move_valid` at N and N+1: the second request falls in CHECK and is dropped. The front end must space requests by at least 2 cycles.
- Display latency: the working grid is visible on `g*Grid_vg` the cycle after the first `frame_start` that arrives at least one cycle after the write.
- All pulses are exactly one cycle wide. All outputs are registered.
- `clr` asserted mid-game returns every output to its reset value immediately (asynchronous reset), including the display grids.

## Test plan
- **P1 row win, no timeout:**
  - Stimulus: `TURN_TIMEOUT`=0; moves 0, 3, 1, 4, 2 with `frame_start` after each.
  - Required: 5 `move_ack` pulses; `game_state`=WIN, `winner`=01, `win_line`=9'h007; `g1Grid_vg`=9'h007, `g2Grid_vg`=9'h018.
- **Illegal moves:**
  - Stimulus: move 4, then move 4 again, then `move_idx`=9.
  - Required: two `move_err` pulses; `turn` stays 1; grids unchanged.
- **Draw:**
  - Stimulus: moves 0, 1, 2, 4, 3, 5, 7, 6, 8.
  - Required: `game_state`=DRAW, `winner`=00, `w1|w2`=9'h1FF; a further move yields `move_err`.
- **Timeout:**
  - Stimulus: `TURN_TIMEOUT`=10, no moves.
  - Required: `turn_timeout` pulses every 10 cycles and `turn` toggles each time. With `move_valid` on the expiry cycle, the move is acked and no timeout pulse occurs.
- **new_game priority:**
  - Stimulus: `new_game` and `move_valid` in the same cycle during PLAY; then repeat in WIN.
  - Required: no ack or err; grids 0, `turn`=0, PLAY. `g1Grid_vg` keeps its old value until the next `frame_start`, then becomes 0.
- **Frame-sync tearing:**
  - Stimulus: a move with no `frame_start` for 1000 cycles.
  - Required: `g*Grid_vg` unchanged throughout, and updated the cycle after the next `frame_start`.
